pe_seq_ctrl: RTL and testbench

Sequencer that drives one pe instance through a complete job: instruction burst, data frame, result collection. Holds a small writable instruction store. On start it replays num_inst instructions on the PE instruction port, streams num_data complex samples from an upstream valid/ready source onto din_pe, then counts num_out results from dout_pe. Sits between the array-level host/config logic and a single PE.

---
 rtl/pe_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
// Drives one PE through a job: replays the instruction store, forwards num_data upstream samples, then counts num_out results.
// Instruction and sample outputs lag the store read/handshake by one cycle; upstream may stall freely, result wait aborts after TIMEOUT idle cycles.
module pe_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int INST_DEPTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 1024,
  localparam int AW = $clog2(INST_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [INST_WIDTH-1:0]   cfg_wdata,
  input  logic                    start,
  input  logic [AW:0]             num_inst,
  input  logic [LEN_WIDTH-1:0]    num_data,
  input  logic [LEN_WIDTH-1:0]    num_out,
  input  logic                    s_data_v,
  input  logic [DATA_WIDTH*2-1:0] s_data,
  output logic                    s_data_rdy,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_pe_v,
  output logic [DATA_WIDTH*2-1:0] din_pe,
  input  logic                    dout_pe_v,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_INST, S_LOAD_DATA, S_WAIT_OUT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [INST_WIDTH-1:0] mem [INST_DEPTH];
  logic [AW:0]           num_inst_q, inst_idx;
  logic [LEN_WIDTH-1:0]  num_data_q, num_out_q, data_cnt, res_cnt;
  logic [TW-1:0]         to_cnt;

  logic start_ok, inst_last, hs, data_last, counting, res_inc, res_met, timeout;

  always_comb begin
    start_ok  = start && (num_inst != '0) && (num_inst <= (AW+1)'(INST_DEPTH));
    inst_last = (inst_idx == num_inst_q);
    hs        = s_data_v && s_data_rdy;
    data_last = hs && (data_cnt == num_data_q - LEN_WIDTH'(1));
    counting  = (state == S_LOAD_INST) || (state == S_LOAD_DATA) || (state == S_WAIT_OUT);
    // res_cnt saturates at num_out_q, so the +1 below cannot wrap
    res_inc   = counting && dout_pe_v && (res_cnt != num_out_q);
    res_met   = (res_cnt == num_out_q) || (res_inc && (res_cnt + LEN_WIDTH'(1) == num_out_q));
    timeout   = !dout_pe_v && (to_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_ok) state_nxt = S_LOAD_INST;
      S_LOAD_INST: if (inst_last) begin
        if (num_data_q != '0)     state_nxt = S_LOAD_DATA;
        else if (num_out_q != '0) state_nxt = S_WAIT_OUT;
        else                      state_nxt = S_DONE;
      end
      S_LOAD_DATA: if (data_last) state_nxt = res_met ? S_DONE : S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (res_met)      state_nxt = S_DONE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = (state == S_DONE);
    s_data_rdy = (state == S_LOAD_DATA) && (data_cnt < num_data_q);
  end

  // Store is only writable between jobs so a running replay never sees a torn program
  always_ff @(posedge clk) begin
    if (cfg_we && state == S_IDLE) mem[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_inst_q <= '0;
      num_data_q <= '0;
      num_out_q  <= '0;
      inst_idx   <= '0;
      data_cnt   <= '0;
      res_cnt    <= '0;
      to_cnt     <= '0;
      inst_in_v  <= 1'b0;
      inst_in    <= '0;
      din_pe_v   <= 1'b0;
      din_pe     <= '0;
      err        <= 1'b0;
    end else begin
      inst_in_v <= 1'b0;
      inst_in   <= '0;
      din_pe_v  <= hs;
      din_pe    <= hs ? s_data : '0;
      to_cnt    <= (state == S_WAIT_OUT && !dout_pe_v) ? to_cnt + TW'(1) : '0;
      if (hs)      data_cnt <= data_cnt + LEN_WIDTH'(1);
      if (res_inc) res_cnt  <= res_cnt + LEN_WIDTH'(1);

      if (state == S_IDLE && start_ok) begin
        num_inst_q <= num_inst;
        num_data_q <= num_data;
        num_out_q  <= num_out;
        inst_idx   <= (AW+1)'(1);
        data_cnt   <= '0;
        res_cnt    <= '0;
        err        <= 1'b0;
        inst_in_v  <= 1'b1;
        inst_in    <= mem['0];
      end else if (state == S_IDLE && start) begin
        err <= 1'b1;
      end

      if (state == S_LOAD_INST && !inst_last) begin
        inst_in_v <= 1'b1;
        inst_in   <= mem[inst_idx[AW-1:0]];
        inst_idx  <= inst_idx + (AW+1)'(1);
      end

      if (state == S_WAIT_OUT && !res_met && timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: per-cycle vector tables plus hand-written reset, timeout and config-lock sequences.
module tb_pe_seq_ctrl;
  localparam int DW = 16, IW = 32, ID = 16, LW = 8, TO = 16, AW = 4;
  localparam logic [31:0] W0 = 32'h60010080, W1 = 32'h60030281, W2 = 32'h60050482;
  localparam logic [31:0] S1 = 32'h00040002, S2 = 32'h00030001, S3 = 32'h00080006;
  localparam logic [31:0] S4 = 32'h00070005, S5 = 32'h000C000A, S6 = 32'h000B0009;

  logic clk = 1'b0;
  logic rst, cfg_we, start, s_data_v, s_data_rdy, inst_in_v, din_pe_v, dout_pe_v, busy, done, err;
  logic [AW-1:0] cfg_addr;
  logic [IW-1:0] cfg_wdata, inst_in;
  logic [AW:0]   num_inst;
  logic [LW-1:0] num_data, num_out;
  logic [2*DW-1:0] s_data, din_pe;

  always #5 clk = ~clk;

  pe_seq_ctrl #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .INST_DEPTH(ID), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .num_inst(num_inst), .num_data(num_data), .num_out(num_out),
    .s_data_v(s_data_v), .s_data(s_data), .s_data_rdy(s_data_rdy),
    .inst_in_v(inst_in_v), .inst_in(inst_in), .din_pe_v(din_pe_v), .din_pe(din_pe),
    .dout_pe_v(dout_pe_v), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic        st;
    logic [4:0]  ni;
    logic [7:0]  nd;
    logic [7:0]  no;
    logic        sv;
    logic [31:0] sd;
    logic        dv;
    logic [69:0] exp_o;
  } vec_t;

  vec_t vt[$];
  int checks = 0, errors = 0;
  wire [69:0] obs = {inst_in_v, inst_in, din_pe_v, din_pe, s_data_rdy, busy, done, err};

  function automatic logic [69:0] pk(input logic iv, input logic [31:0] inst, input logic dv,
                                     input logic [31:0] din, input logic rdy, input logic bsy,
                                     input logic dn, input logic er);
    return {iv, inst, dv, din, rdy, bsy, dn, er};
  endfunction

  task automatic check(input string name, input logic [69:0] exp_o);
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp_o);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic [4:0] ni, input logic [7:0] nd, input logic [7:0] no,
                     input logic sv, input logic [31:0] sd, input logic dv, input logic [69:0] e);
    vec_t v;
    v.st = st; v.ni = ni; v.nd = nd; v.no = no; v.sv = sv; v.sd = sd; v.dv = dv; v.exp_o = e;
    vt.push_back(v);
  endtask

  // start cycle plus the three replayed instruction words
  task automatic push_inst(input logic [7:0] nd, input logic [7:0] no, input logic e0);
    add(1, 5'd3, nd, no, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, e0));
    add(0, 0, 0, 0, 0, 0, 0, pk(1, W0, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(1, W1, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(1, W2, 0, 0, 0, 1, 0, 0));
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vt.size(); i++) begin
      start = vt[i].st; num_inst = vt[i].ni; num_data = vt[i].nd; num_out = vt[i].no;
      s_data_v = vt[i].sv; s_data = vt[i].sd; dout_pe_v = vt[i].dv;
      check($sformatf("%s[%0d]", name, i), vt[i].exp_o);
      tick();
    end
    start = 0; s_data_v = 0; s_data = 0; dout_pe_v = 0;
    vt.delete();
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [IW-1:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic push_short_job(input logic e0);
    push_inst(0, 0, e0);
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; start = 0; num_inst = 0;
    num_data = 0; num_out = 0; s_data_v = 0; s_data = 0; dout_pe_v = 0;
    tick(); tick();
    check("reset", pk(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1;
    tick();

    // program written right before start; the last word lands one cycle before start
    cfg_write(0, W0); cfg_write(1, W1); cfg_write(2, W2);
    push_short_job(0);
    run_table("inst_only");

    // async reset in the middle of the instruction burst
    start = 1; num_inst = 3; num_data = 0; num_out = 0;
    tick();
    start = 0;
    check("mid_w0", pk(1, W0, 0, 0, 0, 1, 0, 0));
    tick();
    #2 rst = 0;
    #1 check("rst_async", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst = 1;
    tick();
    push_short_job(0);
    run_table("after_rst");

    // six samples with a two-cycle upstream gap after the third
    push_inst(6, 0, 0);
    add(0, 0, 0, 0, 1, S1, 0, pk(0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 1, S2, 0, pk(0, 0, 1, S1, 1, 1, 0, 0));
    add(0, 0, 0, 0, 1, S3, 0, pk(0, 0, 1, S2, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, pk(0, 0, 1, S3, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, pk(0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 1, S4, 0, pk(0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 1, S5, 0, pk(0, 0, 1, S4, 1, 1, 0, 0));
    add(0, 0, 0, 0, 1, S6, 0, pk(0, 0, 1, S5, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, S6, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("data");

    // three results, the first arriving while samples are still streaming
    push_inst(2, 3, 0);
    add(0, 0, 0, 0, 1, S1, 1, pk(0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 1, S2, 0, pk(0, 0, 1, S1, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, S2, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("results");

    // one of two results, then silence until the timeout fires
    start = 1; num_inst = 1; num_data = 0; num_out = 2;
    tick();
    start = 0;
    check("to_w0", pk(1, W0, 0, 0, 0, 1, 0, 0));
    tick();
    dout_pe_v = 1;
    check("to_wait", pk(0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    dout_pe_v = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("to_idle%0d", k), pk(0, 0, 0, 0, 0, 1, 0, 0));
    end
    tick();
    check("to_abort", pk(0, 0, 0, 0, 0, 0, 0, 1));
    tick();
    check("to_sticky", pk(0, 0, 0, 0, 0, 0, 0, 1));

    // write while busy is dropped; accepted start clears err
    start = 1; num_inst = 3; num_data = 0; num_out = 0;
    tick();
    start = 0;
    check("lock_w0", pk(1, W0, 0, 0, 0, 1, 0, 0));
    cfg_write(0, 32'hDEADBEEF);
    check("lock_w1", pk(1, W1, 0, 0, 0, 1, 0, 0));
    tick();
    tick();
    check("lock_done", pk(0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    push_short_job(0);
    run_table("replay");

    // illegal instruction counts
    start = 1; num_inst = 0;
    tick();
    start = 0;
    check("ninst0", pk(0, 0, 0, 0, 0, 0, 0, 1));
    tick();
    check("ninst0_hold", pk(0, 0, 0, 0, 0, 0, 0, 1));
    push_short_job(1);
    run_table("clear_err");
    start = 1; num_inst = 5'd17;
    tick();
    start = 0;
    check("ninst17", pk(0, 0, 0, 0, 0, 0, 0, 1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
